// File: rtl/axi4_lite_mem_responder_if.sv
// AXI4-Lite bus bundle between an L1 cache master port and the memory responder.
interface axi4_lite_mem_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4_lite_mem_responder.sv
// AXI4-Lite memory responder: word-organised backing store with configurable
// read/write latency and SLVERR for addresses outside the mapped window.
module axi4_lite_mem_responder #(
    parameter int                    ADDR_WIDTH    = 32,
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    MEM_DEPTH     = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
    parameter int                    READ_LATENCY  = 2,
    parameter int                    WRITE_LATENCY = 1
) (
    input  logic                     s_axi_aclk,
    input  logic                     s_axi_areset,
    axi4_lite_mem_responder_if.slave s_axi
);
    localparam int LANES   = DATA_WIDTH / 8;
    localparam int IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0]      W_LAST  = CNT_W'(WRITE_LATENCY - 1);
    localparam logic [CNT_W-1:0]      R_LAST  = CNT_W'(READ_LATENCY - 1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);

    localparam logic [1:0] W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2;
    localparam logic [1:0] R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2;
    localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;

    // Address lies inside [BASE_ADDR, BASE_ADDR + 4*MEM_DEPTH); low two bits ignored.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] offset;
        offset = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) && ((offset >> 2) < DEPTH_A);
    endfunction

    function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] offset;
        offset = addr - BASE_ADDR;
        return IDX_W'(offset >> 2);
    endfunction

    // ---------------- write channel ----------------
    logic [1:0]            w_state_reg;
    logic [CNT_W-1:0]      w_cnt_reg;
    logic                  aw_held_reg;
    logic                  w_held_reg;
    logic [ADDR_WIDTH-1:0] awaddr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [LANES-1:0]      wstrb_reg;
    logic [1:0]            bresp_reg;

    logic                  aw_fire, w_fire, aw_have, w_have;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [LANES-1:0]      wr_strb;
    logic [IDX_W-1:0]      wr_idx;
    logic                  wr_ok;
    logic                  wr_commit;

    // A held capture blocks its channel until the B handshake consumes it.
    assign s_axi.awready = ~aw_held_reg;
    assign s_axi.wready  = ~w_held_reg;
    assign s_axi.bvalid  = (w_state_reg == W_RESP);
    assign s_axi.bresp   = bresp_reg;

    assign aw_fire = s_axi.awvalid & ~aw_held_reg;
    assign w_fire  = s_axi.wvalid & ~w_held_reg;
    assign aw_have = aw_held_reg | aw_fire;
    assign w_have  = w_held_reg | w_fire;

    // With unit latency the commit uses whatever arrives on the bus this cycle.
    assign wr_addr = aw_held_reg ? awaddr_reg : s_axi.awaddr;
    assign wr_data = w_held_reg ? wdata_reg : s_axi.wdata;
    assign wr_strb = w_held_reg ? wstrb_reg : s_axi.wstrb;
    assign wr_idx  = word_index(wr_addr);
    assign wr_ok   = in_range(wr_addr);

    // Commit strobe fires on the last latency cycle; reset cancels it.
    always_comb begin
        wr_commit = 1'b0;
        if (!s_axi_areset) begin
            if (w_state_reg == W_IDLE)
                wr_commit = aw_have & w_have & (WRITE_LATENCY == 1);
            else if (w_state_reg == W_WAIT)
                wr_commit = (w_cnt_reg == W_LAST);
        end
    end

    // Payload capture for AW and W, independent of each other.
    always_ff @(posedge s_axi_aclk) begin
        if (aw_fire) awaddr_reg <= s_axi.awaddr;
        if (w_fire) begin
            wdata_reg <= s_axi.wdata;
            wstrb_reg <= s_axi.wstrb;
        end
    end

    // Write FSM: collect AW+W, wait out the latency, present B.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            w_state_reg <= W_IDLE;
            w_cnt_reg   <= '0;
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            bresp_reg   <= RESP_OKAY;
        end else begin
            if (aw_fire) aw_held_reg <= 1'b1;
            if (w_fire)  w_held_reg  <= 1'b1;
            case (w_state_reg)
                W_IDLE: begin
                    if (aw_have && w_have) begin
                        if (wr_commit) begin
                            w_state_reg <= W_RESP;
                            bresp_reg   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                        end else begin
                            w_state_reg <= W_WAIT;
                            w_cnt_reg   <= CNT_W'(1);
                        end
                    end
                end
                W_WAIT: begin
                    if (wr_commit) begin
                        w_state_reg <= W_RESP;
                        bresp_reg   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        w_cnt_reg <= w_cnt_reg + CNT_W'(1);
                    end
                end
                W_RESP: begin
                    if (s_axi.bready) begin
                        w_state_reg <= W_IDLE;
                        aw_held_reg <= 1'b0;
                        w_held_reg  <= 1'b0;
                    end
                end
                default: w_state_reg <= W_IDLE;
            endcase
        end
    end

    // ---------------- read channel ----------------
    logic [1:0]            r_state_reg;
    logic [CNT_W-1:0]      r_cnt_reg;
    logic [ADDR_WIDTH-1:0] araddr_reg;
    logic [1:0]            rresp_reg;

    logic                  ar_fire;
    logic                  rd_sample;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] rd_word;

    assign s_axi.arready = (r_state_reg == R_IDLE);
    assign s_axi.rvalid  = (r_state_reg == R_RESP);
    assign s_axi.rresp   = rresp_reg;
    // Errored or idle reads present zero; the RAM output register is only
    // loaded on a sample so it stays stable throughout R_RESP.
    assign s_axi.rdata   = (r_state_reg == R_RESP && rresp_reg == RESP_OKAY) ? rd_word : '0;

    assign ar_fire = s_axi.arvalid & (r_state_reg == R_IDLE);
    assign rd_addr = (r_state_reg == R_IDLE) ? s_axi.araddr : araddr_reg;
    assign rd_idx  = word_index(rd_addr);

    // Memory is sampled on the last cycle before rvalid rises.
    always_comb begin
        rd_sample = 1'b0;
        if (r_state_reg == R_IDLE)
            rd_sample = ar_fire & (READ_LATENCY == 1);
        else if (r_state_reg == R_WAIT)
            rd_sample = (r_cnt_reg == R_LAST);
    end

    // Read address capture on the AR handshake.
    always_ff @(posedge s_axi_aclk) begin
        if (ar_fire) araddr_reg <= s_axi.araddr;
    end

    // Read FSM: accept AR, wait out the latency, hold R until accepted.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_state_reg <= R_IDLE;
            r_cnt_reg   <= '0;
            rresp_reg   <= RESP_OKAY;
        end else begin
            case (r_state_reg)
                R_IDLE: begin
                    if (ar_fire) begin
                        if (rd_sample) begin
                            r_state_reg <= R_RESP;
                            rresp_reg   <= in_range(rd_addr) ? RESP_OKAY : RESP_SLVERR;
                        end else begin
                            r_state_reg <= R_WAIT;
                            r_cnt_reg   <= CNT_W'(1);
                        end
                    end
                end
                R_WAIT: begin
                    if (rd_sample) begin
                        r_state_reg <= R_RESP;
                        rresp_reg   <= in_range(rd_addr) ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        r_cnt_reg <= r_cnt_reg + CNT_W'(1);
                    end
                end
                R_RESP: begin
                    if (s_axi.rready) r_state_reg <= R_IDLE;
                end
                default: r_state_reg <= R_IDLE;
            endcase
        end
    end

    // ---------------- storage ----------------
    // One byte-wide RAM per lane; read-before-write so a colliding read sees old data.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [7:0] mem [MEM_DEPTH];
        logic [7:0] q_reg;

        // Byte-lane write on commit, registered read on sample.
        always_ff @(posedge s_axi_aclk) begin
            if (wr_commit && wr_ok && wr_strb[gi])
                mem[wr_idx] <= wr_data[8*gi +: 8];
            if (rd_sample)
                q_reg <= mem[rd_idx];
        end

        assign rd_word[8*gi +: 8] = q_reg;
    end
endmodule
